tof_tx_scheduler: RTL

- Buffers 20-bit TOF results from the echo processing chain in a small FIFO.
- Paces them into the 5-byte UART frame transmitter: 0xFA header, 3 TOF bytes, 0xFB tail.
- Drives the transmitter's TOF input and its rising-edge send trigger.
- Uses the transmitter's busy flag to sequence frames and enforce a minimum inter-frame gap, so back-to-back measurements are not lost or corrupted.

---
 rtl/tof_tx_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/tof_tx_scheduler.sv
// Queues 20-bit TOF results and paces them into the 5-byte UART frame
// transmitter, sequencing on its busy flag and enforcing an inter-frame gap.
module tof_tx_scheduler #(
  parameter int FIFO_AW      = 2,
  parameter int MIN_GAP      = 5000,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic               clk_50M,
  input  logic               rst_n,
  input  logic               tof_valid,
  input  logic [19:0]        tof_data,
  input  logic               en,
  input  logic               clr_stat,
  input  logic               tx_busy,
  output logic [19:0]        echo_tof_out,
  output logic               send_out,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [7:0]         drop_cnt,
  output logic               overflow,
  output logic               timeout_err,
  output logic               sched_busy
);
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int CNT_MAX = (MIN_GAP > BUSY_TIMEOUT) ? MIN_GAP : BUSY_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0]      TO_LAST  = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0]      GAP_LAST = CW'(MIN_GAP - 1);
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TRIG, S_WAIT_BUSY, S_WAIT_DONE, S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                send_q, send_d;
  logic                terr_q, terr_d;
  logic [19:0]         echo_q, echo_d;
  logic [19:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    level_q;
  logic [7:0]          drop_q;
  logic                ovf_q;
  logic                full, pop, push, drop;

  // LOAD is the only pop; a push landing on it while full frees its own slot.
  assign full = (level_q == LVL_FULL);
  assign pop  = (state_q == S_LOAD);
  assign push = tof_valid && (!full || pop);
  assign drop = tof_valid && full && !pop;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (push) mem_q[wr_ptr_q] <= tof_data;
  end

  // A drop coinciding with clr_stat restarts the count at 1.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else if (drop) begin
      drop_q <= clr_stat ? 8'd1 : ((drop_q == 8'hFF) ? drop_q : drop_q + 8'd1);
      ovf_q  <= 1'b1;
    end else if (clr_stat) begin
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      send_q  <= 1'b0;
      terr_q  <= 1'b0;
      echo_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      send_q  <= send_d;
      terr_q  <= terr_d;
      echo_q  <= echo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    send_d  = send_q;
    echo_d  = echo_q;
    terr_d  = clr_stat ? 1'b0 : terr_q;
    case (state_q)
      S_IDLE: begin
        if (en && (level_q != '0) && !tx_busy) state_d = S_LOAD;
      end
      S_LOAD: begin
        echo_d  = mem_q[rd_ptr_q];
        state_d = S_TRIG;
      end
      S_TRIG: begin
        send_d  = 1'b1;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          send_d  = 1'b0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == TO_LAST) begin
          send_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign echo_tof_out = echo_q;
  assign send_out     = send_q;
  assign fifo_level   = level_q;
  assign drop_cnt     = drop_q;
  assign overflow     = ovf_q;
  assign timeout_err  = terr_q;
  assign sched_busy   = (state_q != S_IDLE);

endmodule
